// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response handshake and data-memory interface bundle for dmem_lsu
interface dmem_lsu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_addr_sel;
    logic [ADDR_W-1:0] req_addr_imm;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic              dmem_write;
    logic              dmem_addr_sel;
    logic [ADDR_W-1:0] dmem_addr_imm;
    logic [ADDR_W-1:0] dmem_addr_reg;
    logic [DATA_W-1:0] mcu_dmem_data;
    logic [DATA_W-1:0] dmem_mcu_data;

    logic              busy;

    modport slave (
        input  req_valid, req_write, req_addr_sel, req_addr_imm, req_addr_reg, req_wdata,
        input  rsp_ready, dmem_mcu_data,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
        output dmem_write, dmem_addr_sel, dmem_addr_imm, dmem_addr_reg, mcu_dmem_data, busy
    );

    modport master (
        output req_valid, req_write, req_addr_sel, req_addr_imm, req_addr_reg, req_wdata,
        output rsp_ready, dmem_mcu_data,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
        input  dmem_write, dmem_addr_sel, dmem_addr_imm, dmem_addr_reg, mcu_dmem_data, busy
    );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store sequencer between control unit and data-memory interface block
module dmem_lsu #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst,
    dmem_lsu_if.slave bus
);
    localparam int         ACC_LEN  = WAIT_CYCLES + 2;
    localparam logic [3:0] CNT_LAST = 4'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              acc_last;

    logic              lat_write;
    logic              lat_addr_sel;
    logic [ADDR_W-1:0] lat_addr_imm;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata;

    logic              write_strobe;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign acc_last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = ACCESS;
            ACCESS:  if (acc_last)      state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
    end

    // The write strobe is armed only at acceptance and dropped at the window's last edge,
    // so it can never be high outside ACCESS; reset clears it at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr_sel <= 1'b0;
            lat_addr_imm <= '0;
            lat_addr_reg <= '0;
            lat_wdata    <= '0;
            write_strobe <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write    <= bus.req_write;
                        lat_addr_sel <= bus.req_addr_sel;
                        lat_addr_imm <= bus.req_addr_imm;
                        lat_addr_reg <= bus.req_addr_reg;
                        lat_wdata    <= bus.req_wdata;
                        write_strobe <= bus.req_write;
                        cnt          <= 4'd0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (acc_last) begin
                        rsp_rdata_q  <= lat_write ? '0 : bus.dmem_mcu_data;
                        rsp_write_q  <= lat_write;
                        rsp_valid_q  <= 1'b1;
                        write_strobe <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    write_strobe <= 1'b0;
                    rsp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dmem_write    = write_strobe;
    assign bus.dmem_addr_sel = lat_addr_sel;
    assign bus.dmem_addr_imm = lat_addr_imm;
    assign bus.dmem_addr_reg = lat_addr_reg;
    assign bus.mcu_dmem_data = lat_wdata;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store sequencer between the MCU control unit and the data-memory tri-state interface block.
- Accepts one load or store request at a time over a valid/ready handshake and latches all request fields.
- Holds the interface control inputs stable for a fixed access window, captures read data, and returns a response over a valid/ready handshake.
- Isolates the control unit from memory timing and guarantees that the interface write strobe is never asserted outside a granted access.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 8, data word width.
- WAIT_CYCLES, 1, extra memory wait states. Access window length ACC_LEN = WAIT_CYCLES+2 cycles. Legal range 0..13.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  control unit request valid.
- req_ready  out  1  LSU can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr_sel  in  1  addressing mode; uses the defs.v encodings (DMEM_IMM_ADDRESS = 0, DMEM_REG_ADDRESS = 1).
- req_addr_imm  in  ADDR_W  direct address.
- req_addr_reg  in  ADDR_W  register-indirect address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  control unit accepts response.
- rsp_write  out  1  echo of the latched req_write.
- rsp_rdata  out  DATA_W  load data; 0 for stores.
- dmem_write  out  1  to interface: write strobe.
- dmem_addr_sel  out  1  to interface: address select.
- dmem_addr_imm  out  ADDR_W  to interface: direct address.
- dmem_addr_reg  out  ADDR_W  to interface: indirect address.
- mcu_dmem_data  out  DATA_W  to interface: store data.
- dmem_mcu_data  in  DATA_W  from interface: registered read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high and overrides everything, including mid-access.
- State after a reset edge:
  - state = IDLE, cnt = 0.
  - All latched request fields = 0.
  - Outputs: dmem_write = 0, dmem_addr_sel = 0, dmem_addr_imm = 0, dmem_addr_reg = 0, mcu_dmem_data = 0, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, busy = 0.
  - req_ready = 1 from the first cycle after the reset edge.
- Reset during ACCESS: dmem_write drops at that same edge; a partial store is abandoned and no response is issued.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- FSM states: IDLE, ACCESS, RESP. A 4-bit counter cnt runs in ACCESS.
- IDLE:
  - req_ready = 1.
  - On req_valid=1 at an edge: latch req_write, req_addr_sel, req_addr_imm, req_addr_reg, req_wdata; set cnt = 0; go to ACCESS.
  - Request inputs are ignored in all other states.
- ACCESS (exactly ACC_LEN cycles):
  - dmem_addr_sel, dmem_addr_imm, dmem_addr_reg and mcu_dmem_data are driven from the latched fields and held constant.
  - dmem_write = latched write for the whole window.
  - cnt increments each edge.
  - At the edge where cnt = ACC_LEN-1:
    - Load: rsp_rdata <= dmem_mcu_data.
    - Store: rsp_rdata <= 0.
    - rsp_write <= latched write; rsp_valid <= 1; dmem_write <= 0; go to RESP.
- RESP:
  - rsp_valid stays 1 and rsp_rdata/rsp_write stay stable until rsp_ready = 1 at an edge.
  - At that edge: rsp_valid <= 0; go to IDLE.
  - rsp_rdata keeps its value until the next response (it is not cleared).
- Throughput:
  - No overlap; req_ready = 0 from acceptance until the response is consumed.
  - Minimum cycles per transaction with rsp_ready held at 1: 1 (accept) + ACC_LEN + 1 (response).
  - Back-to-back: a request presented in the cycle after RESP exits is accepted immediately.
- Simultaneous events:
  - req_valid asserted while in RESP is ignored (not queued).
  - req_valid and rst high at the same edge: reset wins and the request is dropped.
- Interface invariants:
  - dmem_write = 1 only in ACCESS with a store latched.
  - Interface address and data outputs never change during ACCESS.

Test Plan:
- Reset: hold rst 3 cycles during random request traffic -> every output matches the reset values listed above; req_ready = 1 and busy = 0 on the first cycle after rst deasserts.
- Store immediate (WAIT_CYCLES=1): req_write=1, sel=0, imm=0x3C, wdata=0xA5 -> dmem_write=1 for exactly 3 cycles with dmem_addr_imm=0x3C and mcu_dmem_data=0xA5; then rsp_valid=1, rsp_write=1, rsp_rdata=0x00.
- Load register-indirect: sel=1, reg=0x10; the memory model drives dmem_mcu_data=0x5A -> dmem_write stays 0 throughout; rsp_rdata=0x5A; rsp_valid asserts exactly ACC_LEN+1 cycles after acceptance.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable; req_ready=0; a second req_valid is ignored; the second request is accepted only in the cycle after rsp_ready=1.
- Reset mid-store: assert rst on the 2nd ACCESS cycle -> dmem_write=0 from that edge; no rsp_valid ever issues; the next request completes normally.
- Back-to-back with WAIT_CYCLES=0 and WAIT_CYCLES=3: 4 alternating stores and loads with rsp_ready tied to 1 -> per-transaction period is 4 and 7 cycles respectively; load data matches the previously stored values.
